// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor, a - b - bin, LSB first
// One full-subtractor cell plus a registered borrow; result lands WIDTH cycles after start.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] sd_next;
  logic             last;

  assign d       = sa[0] ^ sb[0] ^ br;
  assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  assign sd_next = {d, sd[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));
  assign busy    = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_next;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            // publish the final bit and borrow in the same edge that leaves RUN
            diff  <= sd_next;
            bout  <= br_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept start, giving back-to-back operation
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - scoreboard testbench for serial_sub
// An 8-bit instance takes the directed cases; a 4-bit instance takes the exhaustive sweep.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitors: every done pops one expected result
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) check("done8_unexpected", 1, 0);
      else begin
        logic [8:0] e;
        e = q8.pop_front();
        check("diff8", {24'd0, diff8}, {24'd0, e[7:0]});
        check("bout8", {31'd0, bout8}, {31'd0, e[8]});
      end
    end
    if (rst_n && done4) begin
      if (q4.size() == 0) check("done4_unexpected", 1, 0);
      else begin
        logic [4:0] e;
        e = q4.pop_front();
        check("diff4", {28'd0, diff4}, {28'd0, e[3:0]});
        check("bout4", {31'd0, bout4}, {31'd0, e[4]});
      end
    end
  end

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) check("done8_timeout", 0, 1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    q8.push_back({eb, ed});
    @(posedge clk);
    #1 start8 = 1'b0;
    wait_done8();
  endtask

  initial begin
    logic [7:0] prev;
    #12;
    check("rst_busy", {31'd0, busy8}, 0);
    check("rst_done", {31'd0, done8}, 0);
    check("rst_diff", {24'd0, diff8}, 0);
    check("rst_bout", {31'd0, bout8}, 0);
    @(negedge clk) rst_n = 1'b1;

    // nominal, with latency and busy profile
    @(negedge clk);
    a8 = 8'd100; b8 = 8'd37; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b0, 8'd63});
    @(posedge clk);
    #1 start8 = 1'b0;
    check("nom_busy_e0", {31'd0, busy8}, 1);
    repeat (7) @(posedge clk);
    #1;
    check("nom_busy_e7", {31'd0, busy8}, 1);
    check("nom_done_e7", {31'd0, done8}, 0);
    @(posedge clk);
    #1;
    check("nom_done_e8", {31'd0, done8}, 1);
    check("nom_busy_e8", {31'd0, busy8}, 0);
    @(posedge clk);
    #1 check("nom_done_pulse", {31'd0, done8}, 0);

    op8(8'd5,   8'd10,  1'b0, 8'd251, 1'b1);
    op8(8'd0,   8'd0,   1'b1, 8'd255, 1'b1);
    op8(8'd255, 8'd255, 1'b0, 8'd0,   1'b0);

    // start while busy is ignored; diff holds the previous result
    prev = 8'd0;
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd20; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b0, 8'd30});
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a8 = 8'd9; b8 = 8'd1; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    check("busy_hold_diff", {24'd0, diff8}, {24'd0, prev});
    check("busy_hold_bout", {31'd0, bout8}, 0);
    wait_done8();
    repeat (12) @(negedge clk);

    // back-to-back with start held high
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd1; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b0, 8'd199});
    q8.push_back({1'b1, 8'd255});
    @(posedge clk);
    #1 a8 = 8'd1; b8 = 8'd2;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk);
      #1;
      if (e == 8) check("b2b_done_8", {31'd0, done8}, 1);
      if (e == 9) begin
        start8 = 1'b0;
        check("b2b_busy_9", {31'd0, busy8}, 1);
      end
      if (e == 17) check("b2b_done_17", {31'd0, done8}, 1);
    end
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of a run
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy8}, 0);
    check("mid_rst_done", {31'd0, done8}, 0);
    check("mid_rst_diff", {24'd0, diff8}, 0);
    check("mid_rst_bout", {31'd0, bout8}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(negedge clk);
    op8(8'd7, 8'd3, 1'b0, 8'd4, 1'b0);

    // exhaustive 4-bit sweep; each next start lands in the DONE cycle
    for (int i = 0; i < 512; i++) begin
      int ai, bi, ci, r;
      ai = i & 15; bi = (i >> 4) & 15; ci = (i >> 8) & 1;
      r = ai - bi - ci;
      @(negedge clk);
      a4 = 4'(ai); b4 = 4'(bi); bin4 = ci[0]; start4 = 1'b1;
      q4.push_back({(r < 0) ? 1'b1 : 1'b0, 4'(r & 15)});
      @(posedge clk);
      #1 start4 = 1'b0;
      repeat (4) @(posedge clk);
    end
    repeat (4) @(negedge clk);

    check("q8_drained", q8.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
